queue_alu_exec: RTL and testbench



---
 rtl/queue_cal_pkg.sv | 22 ++
 rtl/queue_alu_exec_if.sv | 29 ++
 rtl/queue_alu_iter_core.sv | 67 ++++++
 rtl/queue_alu_exec.sv | 158 +++++++++++++++
 tb/tb_queue_alu_exec.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/queue_cal_pkg.sv
// Shared encodings for the queue calculator: ALU opcodes, exec FSM states
// and the default datapath width.
package queue_cal_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDSUB = 3'd1,
        S_MUL    = 3'd2,
        S_DIV    = 3'd3,
        S_DONE   = 3'd4
    } alu_state_e;

endpackage

// File: rtl/queue_alu_exec_if.sv
// Request/result bundle between the queue controller and the ALU exec stage.
// master: controller side; slave: exec stage.
interface queue_alu_exec_if #(
    parameter int DATA_W = queue_cal_pkg::DATA_W
);
    logic              start;
    logic [1:0]        alu_op;
    logic [2*DATA_W-1:0] operands;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] result_hi;
    logic              ovf;
    logic              zero;
    logic              div_zero;
    logic              push_req;

    modport master (
        output start, alu_op, operands,
        input  busy, done, result, result_hi,
        input  ovf, zero, div_zero, push_req
    );

    modport slave (
        input  start, alu_op, operands,
        output busy, done, result, result_hi,
        output ovf, zero, div_zero, push_req
    );
endinterface

// File: rtl/queue_alu_iter_core.sv
// Shared bit-serial engine: shift-add multiply and restoring divide,
// one bit per step; fin rises once DATA_W steps have been taken.
module queue_alu_iter_core
    import queue_cal_pkg::*;
#(
    parameter int DATA_W = queue_cal_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi,
    output logic              fin
);
    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] hi_q, lo_q, opd_q;
    logic [CW-1:0]     cnt_q;
    logic              div_q;

    logic [DATA_W:0]   msum;
    logic [DATA_W:0]   shl;
    logic              ge;
    logic [DATA_W-1:0] hi_d, lo_d;

    always_comb begin
        msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        shl  = {hi_q, lo_q[DATA_W-1]};
        ge   = shl >= {1'b0, opd_q};
        if (div_q) begin
            // Truncated subtract is exact: the new remainder is below B.
            hi_d = ge ? shl[DATA_W-1:0] - opd_q : shl[DATA_W-1:0];
            lo_d = {lo_q[DATA_W-2:0], ge};
        end else begin
            hi_d = msum[DATA_W:1];
            lo_d = {msum[0], lo_q[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            opd_q <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            hi_q  <= '0;
            lo_q  <= is_div ? a : b;
            opd_q <= is_div ? b : a;
            cnt_q <= '0;
            div_q <= is_div;
        end else if (step && !fin) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign fin = (cnt_q == CW'(DATA_W));
    assign lo  = lo_q;
    assign hi  = hi_q;
endmodule

// File: rtl/queue_alu_exec.sv
// ALU execution stage behind the operand queue: add/sub, iterative mul/div.
// Define QUEUE_ALU_SAT_EN to make add/sub saturate instead of wrapping.
module queue_alu_exec
    import queue_cal_pkg::*;
#(
    parameter int DATA_W = queue_cal_pkg::DATA_W
) (
    input logic              clk,
    input logic              rst,
    queue_alu_exec_if.slave  bus
);
    alu_state_e        state_q, state_d;
    alu_op_e           op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              load, step;
    logic              cap_as, cap_it, cap_dz;
    logic [DATA_W-1:0] it_lo, it_hi;
    logic              it_fin;

    logic [DATA_W:0]   sum, dif;
    logic [DATA_W-1:0] as_res;
    logic              as_ovf;

    logic [DATA_W-1:0] res_q, hi_q;
    logic              ovf_q, zero_q, dz_q;

    queue_alu_iter_core #(.DATA_W(DATA_W)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .is_div (bus.alu_op == OP_DIV),
        .a      (bus.operands[2*DATA_W-1:DATA_W]),
        .b      (bus.operands[DATA_W-1:0]),
        .lo     (it_lo),
        .hi     (it_hi),
        .fin    (it_fin)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        cap_as  = 1'b0;
        cap_it  = 1'b0;
        cap_dz  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load = 1'b1;
                    unique case (alu_op_e'(bus.alu_op))
                        OP_ADD, OP_SUB: state_d = S_ADDSUB;
                        OP_MUL:         state_d = S_MUL;
                        OP_DIV:         state_d = S_DIV;
                    endcase
                end
            end
            S_ADDSUB: begin
                cap_as  = 1'b1;
                state_d = S_DONE;
            end
            S_MUL: begin
                if (it_fin) begin
                    cap_it  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            S_DIV: begin
                if (b_q == '0) begin
                    cap_dz  = 1'b1;
                    state_d = S_DONE;
                end else if (it_fin) begin
                    cap_it  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sum = {1'b0, a_q} + {1'b0, b_q};
        dif = {1'b0, a_q} - {1'b0, b_q};
        if (op_q == OP_ADD) begin
            as_ovf = sum[DATA_W];
`ifdef QUEUE_ALU_SAT_EN
            as_res = as_ovf ? '1 : sum[DATA_W-1:0];
`else
            as_res = sum[DATA_W-1:0];
`endif
        end else begin
            as_ovf = dif[DATA_W];
`ifdef QUEUE_ALU_SAT_EN
            as_res = as_ovf ? '0 : dif[DATA_W-1:0];
`else
            as_res = dif[DATA_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                op_q <= alu_op_e'(bus.alu_op);
                a_q  <= bus.operands[2*DATA_W-1:DATA_W];
                b_q  <= bus.operands[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= '0;
            hi_q   <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            dz_q   <= 1'b0;
        end else if (cap_as) begin
            res_q  <= as_res;
            hi_q   <= '0;
            ovf_q  <= as_ovf;
            zero_q <= (as_res == '0);
            dz_q   <= 1'b0;
        end else if (cap_it) begin
            res_q  <= it_lo;
            hi_q   <= it_hi;
            ovf_q  <= (op_q == OP_MUL) && (it_hi != '0);
            zero_q <= (it_lo == '0);
            dz_q   <= 1'b0;
        end else if (cap_dz) begin
            res_q  <= '1;
            hi_q   <= a_q;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            dz_q   <= 1'b1;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.push_req  = bus.done & ~dz_q;
    assign bus.result    = res_q;
    assign bus.result_hi = hi_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_queue_alu_exec.sv
// Self-checking bench for queue_alu_exec: directed plan cases plus random
// ops checked against an arithmetic reference model.
module tb_queue_alu_exec;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    queue_alu_exec_if bus ();

    queue_alu_exec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode definitions.
    task automatic model(input int op, input int a, input int b,
                         output int r, output int h, output int o,
                         output int z, output int d, output int l);
        int s;
        r = 0; h = 0; o = 0; d = 0; l = 2;
        case (op)
            0: begin
                s = a + b;
                r = s % 256;
                o = (s > 255) ? 1 : 0;
`ifdef QUEUE_ALU_SAT_EN
                if (o == 1) r = 255;
`endif
            end
            1: begin
                o = (a < b) ? 1 : 0;
                r = (a - b + 256) % 256;
`ifdef QUEUE_ALU_SAT_EN
                if (o == 1) r = 0;
`endif
            end
            2: begin
                s = a * b;
                r = s % 256;
                h = s / 256;
                o = (h != 0) ? 1 : 0;
                l = 10;
            end
            default: begin
                if (b == 0) begin
                    d = 1; r = 255; h = a;
                end else begin
                    r = a / b; h = a % b; l = 10;
                end
            end
        endcase
        z = (r == 0) ? 1 : 0;
    endtask

    // Issue one op; mid>0 pulses an add 1+1 start after edge mid.
    task automatic run_op(input int op, input int a, input int b, input int mid);
        int r, h, o, z, d, l;
        int lat;
        bit busy_ok;
        logic [31:0] rnd;
        model(op, a, b, r, h, o, z, d, l);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.alu_op   = 2'(op);
        bus.operands = {8'(a), 8'(b)};
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            bus.start = (k == mid);
            if (k == mid) begin
                bus.alu_op   = 2'b00;
                bus.operands = 16'h0101;
            end else begin
                rnd = $urandom;
                bus.alu_op   = rnd[17:16];
                bus.operands = rnd[15:0];
            end
            if (bus.done) begin
                lat = k;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
        chk("latency", 32'(lat), 32'(l));
        chk("busy_during", 32'(busy_ok), 32'd1);
        chk("result", 32'(bus.result), 32'(r));
        chk("result_hi", 32'(bus.result_hi), 32'(h));
        chk("ovf", 32'(bus.ovf), 32'(o));
        chk("zero", 32'(bus.zero), 32'(z));
        chk("div_zero", 32'(bus.div_zero), 32'(d));
        chk("push_req", 32'(bus.push_req), 32'(d == 0));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("done_single", 32'(bus.done), 32'd0);
        chk("idle_after", 32'(bus.busy), 32'd0);
        chk("result_hold", 32'(bus.result), 32'(r));
    endtask

    initial begin
        int op, a, b;
        logic [31:0] rnd;
        bus.start    = 1'b0;
        bus.alu_op   = 2'b00;
        bus.operands = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_hi", 32'(bus.result_hi), 32'd0);
        chk("rst_flags", {28'd0, bus.ovf, bus.zero, bus.div_zero, bus.push_req}, 32'd0);
        rst = 1'b0;

        run_op(0, 200, 100, 0);
        run_op(1, 5, 7, 0);
        run_op(1, 7, 7, 0);
        run_op(2, 20, 15, 0);
        run_op(3, 200, 7, 0);
        run_op(3, 9, 0, 0);
        run_op(2, 3, 4, 3);
        run_op(0, 10, 20, 2);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.alu_op   = 2'b10;
        bus.operands = 16'hFFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_result", 32'(bus.result), 32'd0);
        chk("mid_rst_hi", 32'(bus.result_hi), 32'd0);
        chk("mid_rst_flags", {28'd0, bus.ovf, bus.zero, bus.div_zero, bus.push_req}, 32'd0);
        repeat (12) begin
            @(posedge clk);
            #1;
            chk("mid_rst_no_done", 32'(bus.done), 32'd0);
        end
        run_op(0, 1, 2, 0);

        for (int i = 0; i < 40; i++) begin
            rnd = $urandom;
            op = int'(rnd[1:0]);
            a  = int'(rnd[15:8]);
            b  = (rnd[4:2] == 3'd0) ? 0 : int'(rnd[31:24]);
            run_op(op, a, b, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
